// File: rtl/iir_pkg.sv
// Shared types and helpers for the biquad cascade: tap indices,
// FSM state encoding, accumulator sizing and output rounding/saturation.
package iir_pkg;

   localparam int TAPS_PER_STAGE = 5;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_OUT
   } state_e;

   function automatic int acc_width(input int dw, input int cw);
      return dw + cw + 3;
   endfunction

   // Round half up, drop frac bits, clamp to a dw-bit signed range.
   function automatic logic signed [63:0] round_sat(
      input logic signed [63:0] acc,
      input int                 frac,
      input int                 dw
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Coefficient register file, 5 taps per section, b0 resets to unity.
// Ports: write port (we/addr/wdata, wr_ok gate), err pulse, read by {stage,tap}.
module iir_coef_bank
   import iir_pkg::*;
#(
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = 14,
   parameter int NUM_STAGES = 2,
   parameter int ADDR_WIDTH = $clog2(5 * NUM_STAGES)
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  wr_ok_i,
   input  logic                  coef_we_i,
   input  logic [ADDR_WIDTH-1:0] coef_addr_i,
   input  logic [COEF_WIDTH-1:0] coef_wdata_i,
   output logic                  coef_err_o,
   input  logic [2:0]            stage_i,
   input  logic [2:0]            tap_i,
   output logic [COEF_WIDTH-1:0] coef_o
);

   localparam int NC = TAPS_PER_STAGE * NUM_STAGES;
   localparam logic [COEF_WIDTH-1:0] B0_ONE = COEF_WIDTH'(1 << COEF_FRAC);

   logic [COEF_WIDTH-1:0] coef_q [NC];
   logic [COEF_WIDTH-1:0] coef_d [NC];
   logic                  err_q;
   logic                  err_d;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] rd_idx;

   always_comb begin
      in_range = coef_addr_i < ADDR_WIDTH'(NC);
      coef_d   = coef_q;
      err_d    = 1'b0;
      if (coef_we_i) begin
         if (wr_ok_i && in_range) begin
            coef_d[coef_addr_i] = coef_wdata_i;
         end else begin
            err_d = 1'b1;
         end
      end
      rd_idx = ADDR_WIDTH'({3'b000, stage_i} * 6'd5 + {3'b000, tap_i});
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) begin
            coef_q[i] <= (i % TAPS_PER_STAGE == 0) ? B0_ONE : '0;
         end
         err_q <= 1'b0;
      end else begin
         coef_q <= coef_d;
         err_q  <= err_d;
      end
   end

   assign coef_o     = coef_q[rd_idx];
   assign coef_err_o = err_q;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of DF-I biquads sharing one MAC, one tap per cycle.
// Ports: valid/ready sample in, out_valid pulse + y_n, coef write port, bypass, clear.
module iir_biquad_cascade
   import iir_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = 14,
   parameter int NUM_STAGES = 2
) (
   input  logic                                CLK,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic                                clear_state,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_WIDTH-1:0]               x_n,
   output logic                                out_valid,
   output logic [DATA_WIDTH-1:0]               y_n,
   input  logic                                coef_we,
   input  logic [$clog2(5*NUM_STAGES)-1:0]     coef_addr,
   input  logic [COEF_WIDTH-1:0]               coef_wdata,
   output logic                                coef_err
);

   localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH);

   state_e state_q, state_d;
   logic [2:0] stage_q, stage_d;
   logic [2:0] tap_q, tap_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] prod, acc_sum;
   logic signed [DATA_WIDTH-1:0] xin_q, xin_d;
   logic signed [DATA_WIDTH-1:0] y_q, y_d;
   logic signed [DATA_WIDTH-1:0] opnd, y_sat;
   logic signed [DATA_WIDTH-1:0] hx1, hx2, hy1, hy2;
   logic signed [DATA_WIDTH-1:0] x1_q [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] x1_d [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] x2_q [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] x2_d [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] y1_q [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] y1_d [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] y2_q [NUM_STAGES];
   logic signed [DATA_WIDTH-1:0] y2_d [NUM_STAGES];
   logic [COEF_WIDTH-1:0] coef_raw;
   logic signed [COEF_WIDTH-1:0] coef;

   iir_coef_bank #(
      .COEF_WIDTH (COEF_WIDTH),
      .COEF_FRAC  (COEF_FRAC),
      .NUM_STAGES (NUM_STAGES)
   ) u_coef (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .wr_ok_i      (state_q == ST_IDLE),
      .coef_we_i    (coef_we),
      .coef_addr_i  (coef_addr),
      .coef_wdata_i (coef_wdata),
      .coef_err_o   (coef_err),
      .stage_i      (stage_q),
      .tap_i        (tap_q),
      .coef_o       (coef_raw)
   );

   assign coef = coef_raw;

   always_comb begin
      hx1 = '0;
      hx2 = '0;
      hy1 = '0;
      hy2 = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (3'(s) == stage_q) begin
            hx1 = x1_q[s];
            hx2 = x2_q[s];
            hy1 = y1_q[s];
            hy2 = y2_q[s];
         end
      end
      unique case (tap_q)
         TAP_B1:  opnd = hx1;
         TAP_B2:  opnd = hx2;
         TAP_A1:  opnd = hy1;
         TAP_A2:  opnd = hy2;
         default: opnd = xin_q;
      endcase
      prod    = AW'(coef) * AW'(opnd);
      // Feedback taps enter with a minus sign.
      acc_sum = (tap_q >= TAP_A1) ? acc_q - prod : acc_q + prod;
      y_sat   = DATA_WIDTH'(round_sat(64'(acc_sum), COEF_FRAC, DATA_WIDTH));
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      tap_d   = tap_q;
      acc_d   = acc_q;
      xin_d   = xin_q;
      y_d     = y_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      y1_d    = y1_q;
      y2_d    = y2_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && !clear_state) begin
               if (enable) begin
                  xin_d   = x_n;
                  stage_d = '0;
                  tap_d   = TAP_B0;
                  acc_d   = '0;
                  state_d = ST_MAC;
               end else begin
                  y_d     = x_n;
                  state_d = ST_OUT;
               end
            end
         end
         ST_MAC: begin
            acc_d = acc_sum;
            if (tap_q == TAP_A2) begin
               for (int s = 0; s < NUM_STAGES; s++) begin
                  if (3'(s) == stage_q) begin
                     x2_d[s] = x1_q[s];
                     x1_d[s] = xin_q;
                     y2_d[s] = y1_q[s];
                     y1_d[s] = y_sat;
                  end
               end
               acc_d = '0;
               tap_d = TAP_B0;
               if (stage_q == 3'(NUM_STAGES - 1)) begin
                  y_d     = y_sat;
                  state_d = ST_OUT;
               end else begin
                  stage_d = stage_q + 3'd1;
                  xin_d   = y_sat;
               end
            end else begin
               tap_d = tap_q + 3'd1;
            end
         end
         ST_OUT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Clear aborts any sample in flight; y_n keeps its old value.
      if (clear_state) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         tap_d   = TAP_B0;
         stage_d = '0;
         y_d     = y_q;
         for (int s = 0; s < NUM_STAGES; s++) begin
            x1_d[s] = '0;
            x2_d[s] = '0;
            y1_d[s] = '0;
            y2_d[s] = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         tap_q   <= TAP_B0;
         acc_q   <= '0;
         xin_q   <= '0;
         y_q     <= '0;
         for (int s = 0; s < NUM_STAGES; s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         xin_q   <= xin_d;
         y_q     <= y_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUT) && !clear_state;
   assign y_n       = y_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Randomised bench for iir_biquad_cascade against an arithmetic model.
// Default parameters: 16-bit data, S16.14 coefficients, two sections.
module tb_iir_biquad_cascade;

   localparam int NS = 2;
   localparam int NC = 5 * NS;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        clear_state = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x_n = '0;
   logic        out_valid;
   logic [15:0] y_n;
   logic        coef_we = 1'b0;
   logic [3:0]  coef_addr = '0;
   logic [15:0] coef_wdata = '0;
   logic        coef_err;

   int n_run = 0;
   int n_fail = 0;
   int cf [NC];
   int hx1 [NS];
   int hx2 [NS];
   int hy1 [NS];
   int hy2 [NS];

   always #5 CLK = ~CLK;

   iir_biquad_cascade dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .enable      (enable),
      .clear_state (clear_state),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x_n         (x_n),
      .out_valid   (out_valid),
      .y_n         (y_n),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_wdata  (coef_wdata),
      .coef_err    (coef_err)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      for (int s = 0; s < NS; s++) begin
         hx1[s] = 0;
         hx2[s] = 0;
         hy1[s] = 0;
         hy2[s] = 0;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) cf[i] = (i % 5 == 0) ? 16384 : 0;
      model_clear();
   endfunction

   // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded and clamped.
   function automatic int model_filter(input int x);
      longint acc;
      int xs;
      int y;
      xs = x;
      for (int s = 0; s < NS; s++) begin
         acc = longint'(cf[5*s]) * xs + longint'(cf[5*s+1]) * hx1[s]
             + longint'(cf[5*s+2]) * hx2[s] - longint'(cf[5*s+3]) * hy1[s]
             - longint'(cf[5*s+4]) * hy2[s];
         acc = (acc + 8192) >>> 14;
         if (acc > 32767) y = 32767;
         else if (acc < -32768) y = -32768;
         else y = int'(acc);
         hx2[s] = hx1[s];
         hx1[s] = xs;
         hy2[s] = hy1[s];
         hy1[s] = y;
         xs = y;
      end
      return xs;
   endfunction

   function automatic logic [15:0] rcoef(input logic [3:0] a);
      if (int'(a) % 5 >= 3) return 16'($urandom_range(0, 8191)) - 16'd4096;
      return 16'($urandom_range(0, 32767)) - 16'd16384;
   endfunction

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(posedge CLK); #1;
      coef_we = 1'b1;
      coef_addr = a;
      coef_wdata = d;
      if (int'(a) < NC) cf[a] = int'($signed(d));
      @(posedge CLK); #1;
      coef_we = 1'b0;
      chk("wr_err", coef_err, longint'(int'(a) >= NC));
   endtask

   task automatic clr();
      @(posedge CLK); #1;
      clear_state = 1'b1;
      @(posedge CLK); #1;
      clear_state = 1'b0;
      model_clear();
   endtask

   // Handshake one sample; returns in cycle T+1 with the model's answer.
   task automatic hs(input logic [15:0] x, input logic en, input logic w,
                     input logic [3:0] wa, input logic [15:0] wd, output int e);
      int n;
      n = 0;
      @(posedge CLK); #1;
      while (!in_ready && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("ready", in_ready, 1);
      in_valid = 1'b1;
      x_n = x;
      enable = en;
      coef_we = w;
      coef_addr = wa;
      coef_wdata = wd;
      if (w && int'(wa) < NC) cf[wa] = int'($signed(wd));
      e = en ? model_filter(int'($signed(x))) : int'($signed(x));
      @(posedge CLK); #1;
      in_valid = 1'b0;
      coef_we = 1'b0;
      enable = 1'($urandom);
      x_n = 16'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   task automatic send(input logic [15:0] x, input logic en, input logic w,
                       input logic [3:0] wa, input logic [15:0] wd);
      int e;
      int lat;
      hs(x, en, w, wa, wd, e);
      if (w) chk("hs_wr_err", coef_err, longint'(int'(wa) >= NC));
      chk("busy", in_ready, 0);
      wait_out(lat);
      chk("latency", lat, en ? 5 * NS + 1 : 1);
      chk("y", y_n, longint'(e) & 'hFFFF);
   endtask

   task automatic drop();
      logic seen;
      @(posedge CLK); #1;
      in_valid = 1'b1;
      clear_state = 1'b1;
      enable = 1'b1;
      x_n = 16'($urandom);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      clear_state = 1'b0;
      model_clear();
      seen = 1'b0;
      repeat (14) begin
         if (out_valid) seen = 1'b1;
         @(posedge CLK); #1;
      end
      chk("drop_nov", seen, 0);
   endtask

   initial begin
      int e;
      int lat;
      logic seen;
      logic [3:0] a;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_ov", out_valid, 0);
      chk("rst_y", y_n, 0);
      chk("rst_err", coef_err, 0);
      rst_n = 1'b1;

      send(16'h1234, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("ident", y_n, 16'h1234);
      @(posedge CLK); #1;
      chk("ready_after", in_ready, 1);

      clr();
      wr(4'd0, 16'h4000);
      wr(4'd3, 16'hE000);
      for (int i = 0; i < 5; i++) begin
         send((i == 0) ? 16'h4000 : 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0);
         chk("pole", y_n, longint'(16'h4000 >> i));
      end

      hs(16'h4000, 1'b1, 1'b0, 4'd0, 16'h0, e);
      repeat (4) begin
         @(posedge CLK); #1;
      end
      clear_state = 1'b1;
      @(posedge CLK); #1;
      clear_state = 1'b0;
      model_clear();
      chk("clr_ready", in_ready, 1);
      seen = 1'b0;
      repeat (15) begin
         if (out_valid) seen = 1'b1;
         @(posedge CLK); #1;
      end
      chk("clr_nov", seen, 0);
      send(16'h4000, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("clr_p0", y_n, 16'h4000);
      send(16'h0000, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("clr_p1", y_n, 16'h2000);

      hs(16'h0100, 1'b1, 1'b0, 4'd0, 16'h0, e);
      repeat (2) begin
         @(posedge CLK); #1;
      end
      coef_we = 1'b1;
      coef_addr = 4'd0;
      coef_wdata = 16'h1111;
      @(posedge CLK); #1;
      coef_we = 1'b0;
      chk("mac_err", coef_err, 1);
      @(posedge CLK); #1;
      chk("mac_err_pulse", coef_err, 0);
      wait_out(lat);
      chk("mac_y", y_n, longint'(e) & 'hFFFF);
      send(16'h0200, 1'b1, 1'b0, 4'd0, 16'h0);
      wr(4'd10, 16'h5555);

      wr(4'd3, 16'h0000);
      wr(4'd0, 16'h7FFF);
      clr();
      send(16'h7000, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("sat_hi", y_n, 16'h7FFF);
      send(16'h9000, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("sat_lo", y_n, 16'h8000);

      wr(4'd0, 16'h2000);
      wr(4'd3, 16'hF000);
      send(16'h1000, 1'b1, 1'b0, 4'd0, 16'h0);
      send(16'hABCD, 1'b0, 1'b0, 4'd0, 16'h0);
      chk("bypass", y_n, 16'hABCD);
      send(16'h0800, 1'b1, 1'b0, 4'd0, 16'h0);
      send(16'h0300, 1'b1, 1'b1, 4'd5, 16'h3000);

      for (int it = 0; it < 40; it++) begin
         a = 4'($urandom_range(0, 11));
         case ($urandom_range(0, 9))
            0: wr(a, rcoef(a));
            1: clr();
            2: drop();
            default: send(16'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) == 0), a, rcoef(a));
         endcase
      end

      hs(16'h0777, 1'b1, 1'b0, 4'd0, 16'h0, e);
      repeat (3) begin
         @(posedge CLK); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_ready", in_ready, 1);
      chk("arst_ov", out_valid, 0);
      chk("arst_y", y_n, 0);
      @(posedge CLK); #1;
      rst_n = 1'b1;
      model_reset();
      send(16'h5A5A, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("arst_ident", y_n, 16'h5A5A);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
